// File: rtl/number_guess_pkg.sv
// Shared types for the number-guess player side: hint encoding, FSM states, defaults.
package number_guess_pkg;

    typedef enum logic [1:0] {
        HINT_NONE    = 2'b00,
        HINT_LOW     = 2'b01,
        HINT_HIGH    = 2'b10,
        HINT_CORRECT = 2'b11
    } hint_t;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_SHOW,
        ST_NEXT,
        ST_DONE
    } ge_state_t;

    localparam int NUM_ROUNDS_DEFAULT = 3;

    // A digit count of 0 makes no sense for entry, so it behaves as 1.
    function automatic logic [1:0] eff_digits(input logic [1:0] m);
        return (m == 2'd0) ? 2'd1 : m;
    endfunction

endpackage

// File: rtl/bcd_compare3.sv
// Three-digit BCD magnitude compare of a guess against a target, hundreds digit first.
module bcd_compare3
    import number_guess_pkg::*;
(
    input  logic [3:0] g3_i,
    input  logic [3:0] g2_i,
    input  logic [3:0] g1_i,
    input  logic [3:0] t3_i,
    input  logic [3:0] t2_i,
    input  logic [3:0] t1_i,
    output hint_t      hint_o
);
    logic [11:0] g_w;
    logic [11:0] t_w;

    // Concatenated nibbles order exactly like a hundreds-first digit compare.
    assign g_w = {g3_i, g2_i, g1_i};
    assign t_w = {t3_i, t2_i, t1_i};

    always_comb begin
        hint_o = HINT_CORRECT;
        if (g_w < t_w)      hint_o = HINT_LOW;
        else if (g_w > t_w) hint_o = HINT_HIGH;
    end

endmodule

// File: rtl/guess_evaluator.sv
// Player-side guess FSM: assembles keypad digits, grades submits against the round's
// target, counts attempts, advances rounds and keeps score until game over.
module guess_evaluator
    import number_guess_pkg::*;
#(
    parameter int NUM_ROUNDS   = NUM_ROUNDS_DEFAULT,
    parameter int MAX_ATTEMPTS = 7,
    parameter int HOLD_CYCLES  = 50
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Max_digit,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       submit,
    input  logic       new_game,
    input  logic [3:0] target_digit_1,
    input  logic [3:0] target_digit_2,
    input  logic [3:0] target_digit_3,
    output logic [2:0] round,
    output logic [3:0] guess_digit_1,
    output logic [3:0] guess_digit_2,
    output logic [3:0] guess_digit_3,
    output logic [1:0] hint,
    output logic [2:0] attempts,
    output logic [1:0] score,
    output logic       game_over
);
    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [2:0]      ATT_MAX   = 3'(MAX_ATTEMPTS);
    localparam logic [2:0]      RND_LAST  = 3'(NUM_ROUNDS);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

    ge_state_t     state_q;
    logic [2:0]    round_q;
    logic [3:0]    g1_q, g2_q, g3_q;
    logic [1:0]    cnt_q;
    logic [1:0]    maxd_q;
    hint_t         hint_q;
    logic [2:0]    att_q;
    logic [1:0]    score_q;
    logic          over_q;
    logic [HW-1:0] hold_q;
    hint_t         cmp_hint;

    bcd_compare3 u_cmp (
        .g3_i   (g3_q),
        .g2_i   (g2_q),
        .g1_i   (g1_q),
        .t3_i   (target_digit_3),
        .t2_i   (target_digit_2),
        .t1_i   (target_digit_1),
        .hint_o (cmp_hint)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_ENTRY;
            round_q <= 3'd1;
            {g3_q, g2_q, g1_q} <= '0;
            cnt_q   <= '0;
            maxd_q  <= eff_digits(Max_digit);
            hint_q  <= HINT_NONE;
            att_q   <= '0;
            score_q <= '0;
            over_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    // A digit strobe always wins over a simultaneous submit.
                    if (digit_valid) begin
                        if (digit_in <= 4'd9 && cnt_q < maxd_q) begin
                            {g3_q, g2_q, g1_q} <= {g2_q, g1_q, digit_in};
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (submit && cnt_q != 2'd0) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    hint_q  <= cmp_hint;
                    if (att_q != ATT_MAX) att_q <= att_q + 3'd1;
                    hold_q  <= '0;
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (hint_q != HINT_CORRECT && att_q != ATT_MAX) begin
                        {g3_q, g2_q, g1_q} <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ENTRY;
                    end else if (hold_q == HOLD_LAST) begin
                        if (hint_q == HINT_CORRECT && score_q != 2'd3) score_q <= score_q + 2'd1;
                        state_q <= ST_NEXT;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (round_q == RND_LAST) begin
                        over_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        round_q <= round_q + 3'd1;
                        maxd_q  <= eff_digits(Max_digit);
                        {g3_q, g2_q, g1_q} <= '0;
                        cnt_q   <= '0;
                        att_q   <= '0;
                        hint_q  <= HINT_NONE;
                        state_q <= ST_ENTRY;
                    end
                end
                ST_DONE: begin
                    if (new_game) begin
                        round_q <= 3'd1;
                        score_q <= '0;
                        att_q   <= '0;
                        hint_q  <= HINT_NONE;
                        {g3_q, g2_q, g1_q} <= '0;
                        cnt_q   <= '0;
                        maxd_q  <= eff_digits(Max_digit);
                        over_q  <= 1'b0;
                        state_q <= ST_ENTRY;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign round         = round_q;
    assign guess_digit_1 = g1_q;
    assign guess_digit_2 = g2_q;
    assign guess_digit_3 = g3_q;
    assign hint          = hint_q;
    assign attempts      = att_q;
    assign score         = score_q;
    assign game_over     = over_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Self-checking bench for guess_evaluator: directed scenarios plus random games
// graded by an integer-arithmetic model of the game rules.
module tb_guess_evaluator;
    localparam int HOLD = 50;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] Max_digit = 2'd1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       submit = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] target_digit_1, target_digit_2, target_digit_3;
    logic [2:0] round;
    logic [3:0] guess_digit_1, guess_digit_2, guess_digit_3;
    logic [1:0] dut_hint;
    logic [2:0] attempts;
    logic [1:0] score;
    logic       game_over;

    int tgt [0:7];
    int n_chk = 0;
    int n_bad = 0;

    // model of the game: guess held as a plain integer
    int m_round, m_g, m_cnt, m_max, m_hint, m_att, m_score;
    bit m_over;

    assign target_digit_1 = 4'(tgt[round] % 10);
    assign target_digit_2 = 4'((tgt[round] / 10) % 10);
    assign target_digit_3 = 4'((tgt[round] / 100) % 10);

    guess_evaluator #(.NUM_ROUNDS(3), .MAX_ATTEMPTS(7), .HOLD_CYCLES(HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .Max_digit(Max_digit), .digit_valid(digit_valid),
        .digit_in(digit_in), .submit(submit), .new_game(new_game),
        .target_digit_1(target_digit_1), .target_digit_2(target_digit_2),
        .target_digit_3(target_digit_3), .round(round), .guess_digit_1(guess_digit_1),
        .guess_digit_2(guess_digit_2), .guess_digit_3(guess_digit_3), .hint(dut_hint),
        .attempts(attempts), .score(score), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int eff(input int m);
        return (m == 0) ? 1 : m;
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    task automatic new_target();
        tgt[m_round] = $urandom_range(0, pow10(m_max) - 1);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".round"}, int'(round), m_round);
        chk({tag, ".g1"}, int'(guess_digit_1), m_g % 10);
        chk({tag, ".g2"}, int'(guess_digit_2), (m_g / 10) % 10);
        chk({tag, ".g3"}, int'(guess_digit_3), (m_g / 100) % 10);
        chk({tag, ".hint"}, int'(dut_hint), m_hint);
        chk({tag, ".att"}, int'(attempts), m_att);
        chk({tag, ".score"}, int'(score), m_score);
        chk({tag, ".over"}, int'(game_over), int'(m_over));
    endtask

    task automatic model_restart();
        m_round = 1; m_g = 0; m_cnt = 0; m_hint = 0; m_att = 0; m_score = 0; m_over = 0;
        m_max = eff(int'(Max_digit));
        new_target();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_restart();
        chk_outs("rst");
    endtask

    task automatic do_digit(input int d, input bit with_submit);
        digit_valid = 1'b1;
        digit_in = 4'(d);
        submit = with_submit;
        tick();
        digit_valid = 1'b0;
        submit = 1'b0;
        if (!m_over && d <= 9 && m_cnt < m_max) begin
            m_g = (m_g * 10 + d) % 1000;
            m_cnt++;
        end
        chk_outs("dig");
    endtask

    task automatic enter_num(input int n);
        for (int i = m_max - 1; i >= 0; i--) do_digit((n / pow10(i)) % 10, 1'b0);
    endtask

    task automatic do_submit();
        int t;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        if (m_over || m_cnt == 0) begin
            tick();
            tick();
            chk_outs("nosub");
            return;
        end
        chk_outs("sub1");
        tick();
        t = tgt[m_round];
        m_hint = (m_g < t) ? 1 : (m_g > t) ? 2 : 3;
        if (m_att < 7) m_att++;
        chk_outs("hint");
        if (m_hint != 3 && m_att < 7) begin
            tick();
            m_g = 0;
            m_cnt = 0;
            chk_outs("retry");
        end else begin
            repeat (HOLD) tick();
            if (m_hint == 3 && m_score < 3) m_score++;
            chk_outs("held");
            tick();
            if (m_round == 3) m_over = 1;
            else begin
                m_round++; m_g = 0; m_cnt = 0; m_att = 0; m_hint = 0;
                m_max = eff(int'(Max_digit));
                new_target();
            end
            chk_outs("next");
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        if (m_over) model_restart();
        chk_outs("newg");
    endtask

    initial begin
        int steps;
        for (int i = 0; i < 8; i++) tgt[i] = 0;
        Max_digit = 2'd1;
        tick();
        do_reset();
        chk("t0.round", int'(round), 1);

        // game 1, round 1: single-digit target 2
        tgt[1] = 2;
        do_digit(5, 1'b0);
        do_submit();
        chk("t1.hint", int'(dut_hint), 2);
        chk("t1.att", int'(attempts), 1);
        chk("t1.g1", int'(guess_digit_1), 0);
        do_submit();
        do_digit(2, 1'b1);
        tick();
        tick();
        chk_outs("t3.same");
        chk("t3.att", int'(attempts), 1);
        Max_digit = 2'd2;
        do_submit();
        chk("t1.score", int'(score), 1);

        // round 2: two digits, extra digit ignored
        tgt[2] = 57;
        do_digit(5, 1'b0);
        do_digit(7, 1'b0);
        do_digit(9, 1'b0);
        chk("t2.g3", int'(guess_digit_3), 0);
        chk("t2.g2", int'(guess_digit_2), 5);
        chk("t2.g1", int'(guess_digit_1), 7);
        Max_digit = 2'd3;
        do_submit();
        chk("t2.round", int'(round), 3);
        chk("t2.score", int'(score), 2);

        // round 3: three digits, win ends game
        tgt[3] = 123;
        enter_num(123);
        do_submit();
        chk("t5.over", int'(game_over), 1);
        do_digit(4, 1'b0);
        do_submit();
        chk("t5.over2", int'(game_over), 1);
        Max_digit = 2'd1;
        do_new_game();
        chk("t5.round", int'(round), 1);
        chk("t5.score", int'(score), 0);

        // seven wrong submits force the round on
        tgt[1] = 5;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) Max_digit = 2'd0;
            do_digit(3, 1'b0);
            do_submit();
            if (k == 5) chk("t4.att6", int'(attempts), 6);
        end
        chk("t4.round", int'(round), 2);
        chk("t4.score", int'(score), 0);

        // reset in the middle of a correct hold
        tgt[2] = 4;
        do_digit(4, 1'b0);
        submit = 1'b1;
        tick();
        submit = 1'b0;
        repeat (12) tick();
        Max_digit = 2'd2;
        do_reset();
        chk("t6.round", int'(round), 1);
        chk("t6.score", int'(score), 0);
        do_digit(1, 1'b0);
        chk("t6.g1", int'(guess_digit_1), 1);

        // random games
        for (int gm = 0; gm < 4; gm++) begin
            steps = 0;
            while (!m_over && steps < 600) begin
                steps++;
                if ($urandom_range(0, 9) == 0) Max_digit = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: do_digit($urandom_range(0, 12), 1'b0);
                    5, 6:          do_submit();
                    7:             begin enter_num(tgt[m_round]); do_submit(); end
                    8:             do_digit($urandom_range(0, 9), 1'b1);
                    default:       begin tick(); chk_outs("idle"); end
                endcase
            end
            chk("rand.over", int'(game_over), 1);
            Max_digit = 2'($urandom_range(0, 3));
            do_new_game();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
